// File: rtl/text_console_writer_if.sv
// Character input handshake plus text-buffer write port and cursor readback
// for the text console writer.
interface text_console_writer_if;
    logic        char_valid;
    logic [7:0]  char_data;
    logic [7:0]  char_attr;
    logic        char_ready;
    logic        wen;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    // Byte producer (CPU/UART side) that also observes the write port
    modport master (
        output char_valid, char_data, char_attr,
        input  char_ready, wen, waddr, wdata, cursor_row, cursor_col
    );

    // The console writer itself
    modport slave (
        input  char_valid, char_data, char_attr,
        output char_ready, wen, waddr, wdata, cursor_row, cursor_col
    );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into character/attribute writes
// for the VGA text buffer, tracking a cursor and handling LF, CR, BS and FF.
// Sweeps the whole screen blank after reset/FF and blanks the next row on
// every line advance (wrap-around, no scrolling).
module text_console_writer #(
    parameter int         COLS       = 64,
    parameter int         ROWS       = 19,
    parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
    input  logic                 clk,
    input  logic                 rst,
    text_console_writer_if.slave bus
);

    localparam int          TOTAL    = COLS * ROWS;
    localparam int          CW       = $clog2(TOTAL + 1);
    localparam logic [15:0] COLS16   = 16'(COLS);
    localparam logic [CW-1:0] CNT_TOTAL = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_COLS  = CW'(COLS);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [15:0] BLANK    = {CLEAR_ATTR, 8'h00};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_CLRLINE
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt,   w_cnt_nx;
    logic [4:0]      r_row,   w_row_nx;
    logic [6:0]      r_col,   w_col_nx;
    logic            r_wen,   w_wen_nx;
    logic [15:0]     r_waddr, w_waddr_nx;
    logic [15:0]     r_wdata, w_wdata_nx;

    logic [15:0]     w_rowbase;
    logic [4:0]      w_row_adv;
    logic            w_accept;

    assign w_rowbase = 16'(r_row) * COLS16;
    assign w_row_adv = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
    assign w_accept  = bus.char_valid && (r_state == S_IDLE);

    // State register; any reset restarts the full-screen sweep from cell 0
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_nx;
    end

    // Next-state, cursor and write-port decode. The sweep counters run one
    // step past the last write so ready only rises after the final blank
    // cell has been presented.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_wen_nx   = 1'b0;
        w_waddr_nx = r_waddr;
        w_wdata_nx = r_wdata;
        unique case (r_state)
            S_CLEAR: begin
                if (r_cnt == CNT_TOTAL) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_wen_nx   = 1'b1;
                    w_waddr_nx = 16'(r_cnt);
                    w_wdata_nx = BLANK;
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            S_CLRLINE: begin
                // r_row already holds the new row here
                if (r_cnt == CNT_COLS) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_wen_nx   = 1'b1;
                    w_waddr_nx = w_rowbase + 16'(r_cnt);
                    w_wdata_nx = BLANK;
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    unique case (bus.char_data)
                        8'h0A: begin
                            w_col_nx   = '0;
                            w_row_nx   = w_row_adv;
                            w_state_nx = S_CLRLINE;
                            w_cnt_nx   = '0;
                        end
                        8'h0D: w_col_nx = '0;
                        8'h08: begin
                            if (r_col != 7'd0) begin
                                w_col_nx   = r_col - 7'd1;
                                w_wen_nx   = 1'b1;
                                w_waddr_nx = w_rowbase + 16'(r_col) - 16'd1;
                                w_wdata_nx = BLANK;
                            end
                        end
                        8'h0C: begin
                            w_row_nx   = '0;
                            w_col_nx   = '0;
                            w_state_nx = S_CLEAR;
                            w_cnt_nx   = '0;
                        end
                        default: begin
                            w_wen_nx   = 1'b1;
                            w_waddr_nx = w_rowbase + 16'(r_col);
                            w_wdata_nx = {bus.char_attr, bus.char_data};
                            if (r_col == LAST_COL) begin
                                w_col_nx   = '0;
                                w_row_nx   = w_row_adv;
                                w_state_nx = S_CLRLINE;
                                w_cnt_nx   = '0;
                            end else begin
                                w_col_nx = r_col + 7'd1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_nx = S_CLEAR;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Cursor, sweep counter and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt   <= w_cnt_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_wen   <= w_wen_nx;
            r_waddr <= w_waddr_nx;
            r_wdata <= w_wdata_nx;
        end
    end

    assign bus.char_ready = (r_state == S_IDLE);
    assign bus.wen        = r_wen;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;
    assign bus.cursor_row = r_row;
    assign bus.cursor_col = r_col;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: a reference cursor model pushes
// expected {waddr, wdata} writes into a queue; every wen cycle pops and compares.
module tb_text_console_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_console_writer_if bus();

    text_console_writer #(.COLS(64), .ROWS(19), .CLEAR_ATTR(8'h07)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];
    int          m_row, m_col;
    int          wen_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample at the falling edge; check any write
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (bus.wen === 1'b1) begin
            wen_cnt++;
            if (sb.size() == 0) chk("unexpected_write", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                chk("write", {bus.waddr, bus.wdata}, e);
            end
        end else if (bus.wen !== 1'b0) begin
            chk("wen_known", {31'd0, bus.wen}, 32'd0);
        end
    endtask

    task automatic push(input int a, input logic [15:0] d);
        sb.push_back({16'(a), d});
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 64 * 19; i++) push(i, 16'h0700);
    endtask

    task automatic model_advance();
        m_row = (m_row == 18) ? 0 : m_row + 1;
        for (int i = 0; i < 64; i++) push(m_row * 64 + i, 16'h0700);
    endtask

    task automatic model_accept(input logic [7:0] d, input logic [7:0] a);
        case (d)
            8'h0A: begin m_col = 0; model_advance(); end
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) begin m_col--; push(m_row * 64 + m_col, 16'h0700); end
            8'h0C: begin m_row = 0; m_col = 0; push_sweep(); end
            default: begin
                push(m_row * 64 + m_col, {a, d});
                if (m_col == 63) begin m_col = 0; model_advance(); end
                else m_col++;
            end
        endcase
    endtask

    // Tick until char_ready; n = ticks taken, lw/la = write port of the cycle before ready
    task automatic wait_ready(input int bound, output int n, output logic lw, output logic [15:0] la);
        n = 0; lw = 1'b0; la = '0;
        while (bus.char_ready !== 1'b1 && n < bound) begin
            lw = bus.wen; la = bus.waddr;
            tick();
            n++;
        end
        if (bus.char_ready !== 1'b1) chk("ready_timeout", {31'd0, bus.char_ready}, 32'd1);
    endtask

    task automatic chk_cursor(input string tag);
        chk(tag, {20'd0, bus.cursor_row, bus.cursor_col}, 32'(m_row * 128 + m_col));
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int n; logic lw; logic [15:0] la;
        wait_ready(2000, n, lw, la);
        bus.char_valid = 1'b1; bus.char_data = d; bus.char_attr = a;
        model_accept(d, a);
        tick();
        bus.char_valid = 1'b0;
        chk_cursor("cursor_after_accept");
    endtask

    initial begin
        int n; logic lw; logic [15:0] la; int wc;
        rst = 1'b1;
        bus.char_valid = 1'b0; bus.char_data = '0; bus.char_attr = '0;
        m_row = 0; m_col = 0;
        tick(); tick();
        chk("rst_wen",   {31'd0, bus.wen}, 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", 32'(bus.wdata), 32'd0);
        chk("rst_ready", {31'd0, bus.char_ready}, 32'd0);
        chk_cursor("rst_cursor");

        // Power-on sweep
        push_sweep(); wen_cnt = 0;
        rst = 1'b0;
        wait_ready(1400, n, lw, la);
        chk("sweep_wen_count", 32'(wen_cnt), 32'd1216);
        chk("sweep_queue_empty", 32'(sb.size()), 32'd0);
        chk("sweep_last_write", {15'd0, lw, la}, {15'd0, 1'b1, 16'd1215});
        chk("sweep_cycles", 32'(n), 32'd1217);
        chk_cursor("sweep_cursor");

        // First character and back-to-back stream
        send(8'h41, 8'h1E);
        chk("A_write_next_cycle", 32'(sb.size()), 32'd0);
        send(8'h42, 8'h1E);
        send(8'h43, 8'h1E);
        chk("BC_consecutive", 32'(sb.size()), 32'd0);

        // Fill to column 63, then wrap with 'Z'
        for (int i = 3; i < 63; i++) send(8'h30 + 8'(i % 10), 8'h02);
        chk_cursor("at_col63");
        send(8'h5A, 8'h4F);
        wait_ready(200, n, lw, la);
        chk("wrap_busy_cycles", 32'(n), 32'd65);
        chk("wrap_queue_empty", 32'(sb.size()), 32'd0);
        chk_cursor("wrap_cursor");

        // LF on the last row wraps to row 0
        for (int i = 0; i < 17; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 10; i++) send(8'h61, 8'h07);
        chk_cursor("at_18_10");
        send(8'h0A, 8'h00);
        wait_ready(200, n, lw, la);
        chk("lf_wrap_queue_empty", 32'(sb.size()), 32'd0);
        chk_cursor("lf_wrap_cursor");

        // CR: cursor home in the row, no write
        for (int i = 0; i < 5; i++) send(8'h62, 8'h07);
        wc = wen_cnt;
        send(8'h0D, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        chk("cr_no_write", 32'(wen_cnt - wc), 32'd0);
        chk_cursor("cr_cursor");

        // Backspace at (3,5) and at (3,0)
        for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h63, 8'h07);
        send(8'h08, 8'h00);
        chk("bs_write_196", 32'(sb.size()), 32'd0);
        chk_cursor("bs_cursor");
        send(8'h0D, 8'h00);
        wc = wen_cnt;
        send(8'h08, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        chk("bs_col0_no_write", 32'(wen_cnt - wc), 32'd0);
        chk_cursor("bs_col0_cursor");

        // Reset in the middle of a line clear
        send(8'h0A, 8'h00);
        wc = wen_cnt; n = 0;
        while (wen_cnt - wc < 20 && n < 200) begin tick(); n++; end
        chk("clrline_20_writes", 32'(wen_cnt - wc), 32'd20);
        rst = 1'b1;
        tick();
        chk("midrst_wen",   {31'd0, bus.wen}, 32'd0);
        chk("midrst_waddr", 32'(bus.waddr), 32'd0);
        chk("midrst_wdata", 32'(bus.wdata), 32'd0);
        chk("midrst_ready", {31'd0, bus.char_ready}, 32'd0);
        sb.delete(); m_row = 0; m_col = 0;
        chk_cursor("midrst_cursor");
        push_sweep(); wen_cnt = 0;
        rst = 1'b0;
        wait_ready(1400, n, lw, la);
        chk("resweep_wen_count", 32'(wen_cnt), 32'd1216);
        chk("resweep_queue_empty", 32'(sb.size()), 32'd0);

        // Form feed
        for (int i = 0; i < 3; i++) send(8'h64, 8'h07);
        wen_cnt = 0;
        send(8'h0C, 8'h00);
        wait_ready(1400, n, lw, la);
        chk("ff_wen_count", 32'(wen_cnt), 32'd1216);
        chk("ff_queue_empty", 32'(sb.size()), 32'd0);
        chk_cursor("ff_cursor");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
